// File: rtl/div_unit.sv
// div_unit: multicycle radix-2 restoring divider; quotient on lo, remainder on hi.
// Build macro DIV_SIGNED_EN selects signed (div) semantics; undefined gives unsigned (divu).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

`ifdef DIV_SIGNED_EN
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        if (x[WIDTH-1]) begin
            m = negate(x);
        end else begin
            m = x;
        end
        return m;
    endfunction

    logic quo_neg_r;
    logic rem_neg_r;
`endif

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] num_r;
    logic [WIDTH-1:0] den_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic             accept_s;
    logic             zero_s;
    logic [WIDTH-1:0] num_abs_s;
    logic [WIDTH-1:0] den_abs_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;

    // Next-state logic; DONE accepts a new start so back-to-back requests lose no cycle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        zero_s       = (divisor == {WIDTH{1'b0}});
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (zero_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = CALC;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == CW'(WIDTH - 1)) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX:     state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand magnitudes and the trial subtraction of one restoring step.
    always_comb begin
`ifdef DIV_SIGNED_EN
        num_abs_s = magnitude(dividend);
        den_abs_s = magnitude(divisor);
`else
        num_abs_s = dividend;
        den_abs_s = divisor;
`endif
        shifted_s = {rem_r, num_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, den_r};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and result load.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
            num_r   <= {WIDTH{1'b0}};
            den_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
`ifdef DIV_SIGNED_EN
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
`endif
        end else if (accept_s && !zero_s) begin
            count_r <= {CW{1'b0}};
            num_r   <= num_abs_s;
            den_r   <= den_abs_s;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
`ifdef DIV_SIGNED_EN
            quo_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_r <= dividend[WIDTH-1];
`endif
        end else if (state_r == CALC) begin
            num_r   <= {num_r[WIDTH-2:0], 1'b0};
            quo_r   <= {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
            count_r <= count_r + CW'(1);
            // A clear sign bit means the divisor fitted: keep the difference.
            if (!diff_s[WIDTH]) begin
                rem_r <= diff_s[WIDTH-1:0];
            end else begin
                rem_r <= shifted_s[WIDTH-1:0];
            end
        end else if (state_r == FIX) begin
`ifdef DIV_SIGNED_EN
            lo_r <= quo_neg_r ? negate(quo_r) : quo_r;
            hi_r <= rem_neg_r ? negate(rem_r) : rem_r;
`else
            lo_r <= quo_r;
            hi_r <= rem_r;
`endif
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == DONE);
            div_zero_r <= (state_next_s == DONE) && accept_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of {div_zero, hi, lo} expectations.
// Covers both builds; DIV_SIGNED_EN selects the signed expectations.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] sb[$];
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ph, input logic [31:0] pl);
        logic [64:0] r;
`ifdef DIV_SIGNED_EN
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic signed [31:0] q;
        logic signed [31:0] m;
        sa = a;
        sd = b;
        if (b == 32'd0) begin
            r = {1'b1, ph, pl};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {1'b0, 32'd0, 32'h8000_0000};
        end else begin
            q = sa / sd;
            m = sa % sd;
            r = {1'b0, m, q};
        end
`else
        if (b == 32'd0) begin
            r = {1'b1, ph, pl};
        end else begin
            r = {1'b0, a % b, a / b};
        end
`endif
        return r;
    endfunction

    task automatic push_exp(input logic [64:0] e);
        sb.push_back(e);
        if (!e[64]) begin
            last_hi = e[63:32];
            last_lo = e[31:0];
        end
    endtask

    // Called at a negedge; launches one request and waits (bounded) for its done pulse.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output logic [31:0] h, output logic [31:0] l, output logic dz);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat = -1; h = 32'd0; l = 32'd0; dz = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = i; h = hi; l = lo; dz = div_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta[5];
        logic [31:0] tb[5];
        logic [31:0] th[5];
        logic [31:0] tl[5];
        int lat; logic [31:0] h; logic [31:0] l; logic dz; logic [64:0] e;
`ifdef DIV_SIGNED_EN
        ta = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100};
        tb = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7};
        th = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd2};
        tl = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14};
`else
        ta = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        tb = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd7};
        th = '{32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'd2};
        tl = '{32'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'd0, 32'd14};
`endif
        for (int i = 0; i < 5; i++) begin
            push_exp({1'b0, th[i], tl[i]});
            do_div(ta[i], tb[i], lat, h, l, dz);
            e = sb.pop_front();
            checks++;
            if (lat != 34) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want 34", i, lat);
            end
            checks++;
            if ({dz, h, l} !== e) begin
                errors++;
                $display("FAIL directed_result[%0d] got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                         i, dz, h, l, e[64], e[63:32], e[31:0]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_busy_clear[%0d] got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] h; logic [31:0] l; logic dz; logic [64:0] e;
        push_exp({1'b1, last_hi, last_lo});
        do_div(32'h1234_5678, 32'd0, lat, h, l, dz);
        e = sb.pop_front();
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL zero_latency got %0d want 1", lat);
        end
        checks++;
        if ({dz, h, l} !== e) begin
            errors++;
            $display("FAIL zero_result got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                     dz, h, l, e[64], e[63:32], e[31:0]);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("FAIL zero_after got busy=%b done=%b dz=%b want 000", busy, done, div_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba[4];
        logic [31:0] bb[4];
        int bl[4];
        int lat; logic [31:0] h; logic [31:0] l; logic dz; logic [64:0] e;
        ba = '{32'd1000, 32'hFFFF_FF00, 32'd55, 32'h7FFF_FFFF};
        bb = '{32'd3, 32'd0, 32'hFFFF_FFF0, 32'd10};
        bl = '{34, 1, 34, 34};
        for (int i = 0; i < 4; i++) begin
            push_exp(model(ba[i], bb[i], last_hi, last_lo));
            do_div(ba[i], bb[i], lat, h, l, dz);
            e = sb.pop_front();
            checks++;
            if (lat != bl[i]) begin
                errors++;
                $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, bl[i]);
            end
            checks++;
            if ({dz, h, l} !== e) begin
                errors++;
                $display("FAIL b2b_result[%0d] got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                         i, dz, h, l, e[64], e[63:32], e[31:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a; logic [31:0] b;
        int lat; logic [31:0] h; logic [31:0] l; logic dz; logic [64:0] e;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) b = {{16{b[15]}}, b[15:0]};
            if (i % 7 == 3) b = 32'd0;
            push_exp(model(a, b, last_hi, last_lo));
            do_div(a, b, lat, h, l, dz);
            e = sb.pop_front();
            checks++;
            if ({dz, h, l} !== e || lat != (b == 32'd0 ? 1 : 34)) begin
                errors++;
                $display("FAIL random[%0d] %h/%h got dz=%b hi=%h lo=%h lat=%0d want dz=%b hi=%h lo=%h",
                         i, a, b, dz, h, l, lat, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat; logic [31:0] h; logic [31:0] l; logic [64:0] e; logic dz;
        push_exp(model(32'd1000, 32'd3, last_hi, last_lo));
        lat = -1; h = 32'd0; l = 32'd0; dz = 1'b0;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 10) begin dividend = 32'd5; divisor = 32'd1; start = 1'b1; end
            if (i == 11) start = 1'b0;
            if (done === 1'b1) begin
                lat = i; h = hi; l = lo; dz = div_zero;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (lat != 34 || {dz, h, l} !== e) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d dz=%b hi=%h lo=%h want lat=34 dz=%b hi=%h lo=%h",
                     lat, dz, h, l, e[64], e[63:32], e[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] h; logic [31:0] l; logic dz; logic [64:0] e;
        int seen = 0;
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_hi = 32'd0;
        last_lo = 32'd0;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen);
        end
        push_exp(model(32'd100, 32'd7, last_hi, last_lo));
        do_div(32'd100, 32'd7, lat, h, l, dz);
        e = sb.pop_front();
        checks++;
        if (lat != 34 || {dz, h, l} !== e || l !== 32'd14 || h !== 32'd2) begin
            errors++;
            $display("FAIL reset_mid_restart got lat=%0d dz=%b hi=%h lo=%h want lat=34 dz=0 hi=2 lo=e",
                     lat, dz, h, l);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_random();
        test_ignore_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
